// File: rtl/load_store_unit.sv
// Load/store unit between a request/response pipeline and a word-wide data
// memory. It handles byte/half/word accesses with little-endian lanes, does
// sub-word stores as read-modify-write, and flags misaligned, out-of-range
// and illegal-size requests without touching memory.
module load_store_unit #(
    parameter int ADDR_WIDTH = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_store;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_err;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;
    logic [31:0] w_lane_mask;
    logic [31:0] w_lane_data;
    logic [31:0] w_merged;

    assign w_accept = req_valid && (r_state == ST_IDLE);

    // Request legality: illegal size, misalignment, or address beyond memory depth
    always_comb begin
        w_err = 1'b0;
        if (req_size == 2'b11) begin
            w_err = 1'b1;
        end
        if ((req_size == 2'b01) && req_addr[0]) begin
            w_err = 1'b1;
        end
        if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) begin
            w_err = 1'b1;
        end
        if ((req_addr >> (ADDR_WIDTH + 2)) != '0) begin
            w_err = 1'b1;
        end
    end

    // Load extraction: move the addressed lane to bit 0, then extend
    always_comb begin
        w_shifted   = mem_rdata >> {r_addr[1:0], 3'b000};
        w_load_data = mem_rdata;
        case (r_size)
            2'b00:   w_load_data = r_unsigned ? {24'h000000, w_shifted[7:0]}
                                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_data = r_unsigned ? {16'h0000, w_shifted[15:0]}
                                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = mem_rdata;
        endcase
    end

    // Store merge: replace only the addressed lane(s) of the word read back
    always_comb begin
        w_lane_mask = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << {r_addr[1:0], 3'b000};
        w_lane_data = r_wdata << {r_addr[1:0], 3'b000};
        if (r_size == 2'b10) begin
            w_merged = r_wdata;
        end else begin
            w_merged = (r_word & ~w_lane_mask) | (w_lane_data & w_lane_mask);
        end
    end

    // State register; reset drops any in-flight request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_err) begin
                        w_next = ST_RESP;
                    end else if (req_store && (req_size == 2'b10)) begin
                        w_next = ST_WRITE;
                    end else begin
                        w_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                mem_read = 1'b0;
                mem_addr = {2'b00, r_addr[31:2]};
                w_next   = r_store ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                mem_write = 1'b1;
                mem_addr  = {2'b00, r_addr[31:2]};
                mem_wdata = w_merged;
                w_next    = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = r_rdata;
                resp_err   = r_err;
                if (resp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request capture at accept; memory sample on the edge leaving READ
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_store    <= 1'b0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_word     <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_store    <= req_store;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rdata    <= '0;
            r_err      <= w_err;
        end else if (r_state == ST_READ) begin
            if (r_store) begin
                r_word <= mem_rdata;
            end else begin
                r_rdata <= w_load_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a byte-array reference model predicts
// response data, error flag, latency, merged write word and access counts;
// one negedge process compares the DUT against those predictions.
module tb_load_store_unit;

    localparam int AW = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;
    int reads_seen  = 0;
    int writes_seen = 0;

    logic        busy = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_wdata = '0;
    logic [31:0] exp_idx = '0;

    logic [31:0] dmem    [0:63];
    logic [31:0] ref_mem [0:63];
    bit          mem_loaded = 1'b0;

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] img(input int i);
        if (i == 4) return 32'h8899AABB;
        return 32'h1F2E3D4C + 32'h01000193 * i;
    endfunction

    // Memory drives garbage while its output is disabled
    assign mem_rdata = mem_read ? 32'hDEADBEEF : dmem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) dmem[i] <= img(i);
            mem_loaded <= 1'b1;
        end else if (mem_write) begin
            dmem[mem_addr[5:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-level view of the memory word
    function automatic void model(input logic st, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd,
                                  output logic [31:0] nw, output int lat);
        int nbytes;
        int lane;
        logic [7:0] b [4];
        logic [31:0] word;
        longint v;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        lane   = int'(a % 4);
        err    = (sz == 2'd3) || ((a % nbytes) != 0) || ({32'd0, a} >= (64'd1 << (AW + 2)));
        word   = ref_mem[(a / 4) % 64];
        for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
        rd = '0;
        nw = word;
        if (err) begin
            lat = 1;
        end else if (!st) begin
            v = 0;
            for (int i = 0; i < nbytes; i++) v += longint'(b[lane + i]) * (longint'(1) << (8 * i));
            if (!uns && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
                v -= (longint'(1) << (8 * nbytes));
            rd  = v[31:0];
            lat = 2;
        end else begin
            for (int i = 0; i < nbytes; i++) b[lane + i] = wd[8*i +: 8];
            nw  = {b[3], b[2], b[1], b[0]};
            lat = (nbytes == 4) ? 2 : 3;
        end
    endfunction

    // Per-cycle comparison against the current expectation
    always @(negedge clk) begin
        if (rst) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, !busy});
            if (!mem_read) begin
                reads_seen++;
                chk("rd_addr", mem_addr, exp_idx);
            end
            if (mem_write) begin
                writes_seen++;
                chk("wr_addr", mem_addr, exp_idx);
                chk("wr_data", mem_wdata, exp_wdata);
                chk("wr_read_hi", {31'd0, mem_read}, 32'd1);
            end
            if (resp_valid) begin
                chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
                chk("resp_rdata", resp_rdata, exp_rdata);
            end
        end
    end

    task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int hold, input logic junk);
        logic e;
        logic [31:0] r, nw;
        int lat, n, r0, w0;
        model(st, sz, uns, a, wd, e, r, nw, lat);
        exp_err   = e;
        exp_rdata = r;
        exp_wdata = nw;
        exp_idx   = a >> 2;
        r0 = reads_seen;
        w0 = writes_seen;
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        busy = 1'b1;
        // Scramble inputs after accept; junk also keeps req_valid high
        req_valid = junk; req_store = ~st; req_size = sz ^ 2'b01;
        req_unsigned = ~uns; req_addr = ~a; req_wdata = ~wd;
        n = 1;
        while (!resp_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
        repeat (hold) begin
            chk("held_valid", {31'd0, resp_valid}, 32'd1);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        busy = 1'b0;
        chk("resp_drop", {31'd0, resp_valid}, 32'd0);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("read_count", reads_seen - r0, (!e && (!st || sz != 2'd2)) ? 1 : 0);
        chk("write_count", writes_seen - w0, (!e && st) ? 1 : 0);
        if (!e && st) ref_mem[(a / 4) % 64] = nw;
    endtask

    initial begin
        logic e;
        logic [31:0] r, nw;
        int lat, n;

        for (int i = 0; i < 64; i++) ref_mem[i] = img(i);
        rst = 1'b0;
        req_valid = 1'b0; req_store = 1'b0; req_size = '0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd1);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Hand-computed pins on the model itself
        model(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, e, r, nw, lat);
        chk("pin_lb_data", r, 32'hFFFFFF99);
        chk("pin_lb_lat", lat, 2);
        model(1'b1, 2'd1, 1'b0, 32'h10, 32'h1234, e, r, nw, lat);
        chk("pin_sh_word", nw, 32'h88991234);
        chk("pin_sh_lat", lat, 3);
        model(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, e, r, nw, lat);
        chk("pin_lw_mis", {31'd0, e}, 32'd1);
        model(1'b0, 2'd2, 1'b0, 32'h0040_0000, 32'h0, e, r, nw, lat);
        chk("pin_lw_range", {31'd0, e}, 32'd1);

        //     store size  uns   addr            wdata          hold junk
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0012, 32'h0,         0,   1'b0);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_0010, 32'h0000_1234, 0,   1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0,         0,   1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0040_0000, 32'h0,         0,   1'b0);
        do_req(1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0,         5,   1'b1);
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0,         0,   1'b0);
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_0023, 32'hFFFF_FFA5, 0,   1'b0);
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 0,   1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0,         1,   1'b0);
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_0021, 32'h0,         0,   1'b0);
        do_req(1'b0, 2'd3, 1'b0, 32'h0000_0008, 32'h0,         0,   1'b0);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_0015, 32'h0000_7777, 0,   1'b0);
        do_req(1'b1, 2'd2, 1'b0, 32'h003F_FFFC, 32'h1357_9BDF, 0,   1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h003F_FFFC, 32'h0,         0,   1'b0);
        do_req(1'b1, 2'd2, 1'b0, 32'h0040_0000, 32'h5555_5555, 0,   1'b0);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_0026, 32'h0000_BEEF, 2,   1'b1);

        // Reset while a byte store sits in WRITE
        model(1'b1, 2'd0, 1'b0, 32'h31, 32'h5A, e, r, nw, lat);
        exp_err = e; exp_rdata = r; exp_wdata = nw; exp_idx = 32'd12;
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h31; req_wdata = 32'h5A;
        @(posedge clk); #1;
        busy = 1'b1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_write && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_reach_write", {31'd0, mem_write}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_wr_drop", {31'd0, mem_write}, 32'd0);
        chk("rst_wr_read", {31'd0, mem_read}, 32'd1);
        chk("rst_wr_addr", mem_addr, 32'd0);
        chk("rst_wr_wdata", mem_wdata, 32'd0);
        chk("rst_wr_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        busy = 1'b0;
        #1;
        chk("rst_rel_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_write", {31'd0, mem_write}, 32'd0);
        chk("rst_word_kept", dmem[12], ref_mem[12]);

        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0031, 32'h0,         0,   1'b0);

        for (int i = 0; i < 64; i++) chk("mem_image", dmem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, meaning word-index width of the downstream data memory (depth 2^ADDR_WIDTH words of 32 bits).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_store  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-008 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  misaligned, out-of-range or illegal-size request.
REQ-015 SHALL have port mem_addr  output  32  word index {2'b00, req_addr[31:2]}.
REQ-016 SHALL have port mem_wdata  output  32  merged word to write.
REQ-017 SHALL have port mem_read  output  1  memory output-disable: memory drives valid mem_rdata only while mem_read=0.
REQ-018 SHALL have port mem_write  output  1  word write strobe, captured by memory on the rising edge.
REQ-019 SHALL have port mem_rdata  input  32  combinational read of mem_addr.

Function
REQ-020 States: IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-021 Accept on req_valid&&req_ready; latch store, size, unsigned, addr and wdata; later input changes are ignored.
REQ-022 Error check at accept: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:ADDR_WIDTH+2] nonzero. An error goes IDLE->RESP with resp_err=1 and resp_rdata=0, and no memory access occurs.
REQ-023 Load: IDLE->READ->RESP. In READ, mem_read=0 and mem_rdata is sampled on the edge leaving READ.
REQ-024 Word store: IDLE->WRITE->RESP.
REQ-025 Byte/half store: IDLE->READ->WRITE->RESP (read-modify-write). Bytes not addressed keep their read values.
REQ-026 mem_write=1 for exactly the one cycle spent in WRITE and 0 in all other states; mem_wdata is valid in WRITE.
REQ-027 mem_read=1 in all states except READ.
REQ-028 Lanes are little-endian: byte lane = addr[1:0]; half lane = addr[1].
REQ-029 Load extraction: the selected byte or half is shifted to bit 0 and then extended per req_unsigned; word loads pass through unchanged.
REQ-030 Latency from the accept edge to resp_valid=1: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-031 In RESP, resp_valid=1; resp_rdata and resp_err are held stable until resp_ready=1. On that edge the unit returns to IDLE. A new request is accepted no earlier than the following cycle.
REQ-032 resp_ready is ignored outside RESP; req_valid is ignored outside IDLE.
REQ-033 mem_addr is driven from the latched address in READ and WRITE and is 0 in IDLE and RESP.

Reset
REQ-034 rst=0 asynchronously forces IDLE, latched fields to 0, and outputs to: req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_err=0, mem_write=0, mem_read=1, mem_addr=0, mem_wdata=0.
REQ-035 Reset asserted in READ or WRITE drops the request. mem_write SHALL be 0 from the reset assertion onward, and no partial write is issued after release.

Verification
REQ-036 Memory word 4 = 32'h8899AABB; load byte, addr 0x12, signed -> resp_rdata=32'hFFFFFF99, resp_err=0, resp 2 cycles after accept.
REQ-037 Same word; store half 16'h1234 at addr 0x10 -> one mem_write, mem_wdata=32'h88991234, resp 3 cycles after accept.
REQ-038 Load word at addr 0x6 -> resp_err=1, resp_rdata=0, no mem_write and mem_read never 0, resp 1 cycle after accept.
REQ-039 Load word at addr 32'h0040_0000 with ADDR_WIDTH=20 -> resp_err=1, no memory access.
REQ-040 Load with resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata are held stable; req_ready=0 throughout; return to IDLE on the resp_ready edge.
REQ-041 Sub-word store with rst pulsed low during WRITE -> mem_write drops immediately, the memory word is unchanged, and req_ready=1 after release.
